// File: rtl/mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of the shared mem_if slave port.
// Master 0 is the stimulus reader, master 1 the result/log writer. The grant
// is registered and only moves at transfer boundaries. Round-robin fairness
// is bounded by MAX_HOLD accepts, and a read+write issued together by the
// owner raises a sticky protocol error flag.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no owner, mem_* driven to zero, both masters stalled
// S_GRANT0| master 0 owns mem_if
// S_GRANT1| master 1 owns mem_if
module mem_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int HOLD_WIDTH = 4,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [BE_WIDTH-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_waitrequest,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [BE_WIDTH-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_waitrequest,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BE_WIDTH-1:0]   mem_byteenable,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_waitrequest,
  output logic [1:0]            grant,
  output logic                  protocol_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT0 = 2'd1,
    S_GRANT1 = 2'd2
  } state_t;

  localparam logic [HOLD_WIDTH:0]   MAX_HOLD_W = (HOLD_WIDTH + 1)'(MAX_HOLD);
  localparam logic [HOLD_WIDTH:0]   ONE_W      = (HOLD_WIDTH + 1)'(1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_SAT   = '1;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic                  perr_q, perr_d;

  logic                  req0, req1;
  logic                  own_id, own_req, oth_req, own_rw_both, granted;
  logic [HOLD_WIDTH:0]   hold_inc;

  assign req0        = m0_read | m0_write;
  assign req1        = m1_read | m1_write;
  assign granted     = (state_q != S_IDLE);
  assign own_id      = (state_q == S_GRANT1);
  assign own_req     = own_id ? req1 : req0;
  assign oth_req     = own_id ? req0 : req1;
  assign own_rw_both = own_id ? (m1_read & m1_write) : (m0_read & m0_write);
  // One extra bit so the MAX_HOLD compare cannot wrap at the saturation value.
  assign hold_inc    = {1'b0, hold_q} + ONE_W;

  // State, round-robin history, hold counter and sticky error register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state: grant moves only on accept (hold expired) or owner drop.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    perr_d  = perr_q | (granted & own_rw_both);
    case (state_q)
      S_IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? S_GRANT0 : S_GRANT1;
        end else if (req0) begin
          state_d = S_GRANT0;
        end else if (req1) begin
          state_d = S_GRANT1;
        end
      end
      S_GRANT0, S_GRANT1: begin
        if (own_req) begin
          if (!mem_waitrequest) begin
            if (oth_req && (hold_inc >= MAX_HOLD_W)) begin
              state_d = own_id ? S_GRANT0 : S_GRANT1;
              hold_d  = '0;
              last_d  = own_id;
            end else if (hold_q != HOLD_SAT) begin
              hold_d = hold_inc[HOLD_WIDTH-1:0];
            end
          end
        end else begin
          hold_d  = '0;
          last_d  = own_id;
          state_d = oth_req ? (own_id ? S_GRANT0 : S_GRANT1) : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus mux from the registered grant; idle drives zeros and stalls both.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      S_GRANT0: begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_read       = m0_read;
        mem_write      = m0_write;
        mem_writedata  = m0_writedata;
        m0_waitrequest = mem_waitrequest;
      end
      S_GRANT1: begin
        mem_address    = m1_address;
        mem_byteenable = m1_byteenable;
        mem_read       = m1_read;
        mem_write      = m1_write;
        mem_writedata  = m1_writedata;
        m1_waitrequest = mem_waitrequest;
      end
      default: ;
    endcase
  end

  assign grant        = {state_q == S_GRANT1, state_q == S_GRANT0};
  assign protocol_err = perr_q;
  assign m0_readdata  = mem_readdata;
  assign m1_readdata  = mem_readdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic, all compared against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int HW = 4;
  localparam int MH = 8;
  localparam int HOLD_MAX = (1 << HW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic [BW-1:0] m0_byteenable = '0, m1_byteenable = '0;
  logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata = '0;
  logic          mem_waitrequest = 1'b0;
  logic [1:0]    grant;
  logic          protocol_err;

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .HOLD_WIDTH(HW), .MAX_HOLD(MH)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
    .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
    .m1_waitrequest(m1_waitrequest),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest),
    .grant(grant), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (-1 none), who was served last, how
  // many accepts the current owner has had, and the sticky error.
  int owner;
  int last_served;
  int accepts;
  bit err_seen;

  task automatic model_reset();
    owner       = -1;
    last_served = 1;
    accepts     = 0;
    err_seen    = 1'b0;
  endtask

  task automatic model_step();
    bit req [2];
    bit rw_both [2];
    int other;
    req[0]     = m0_read | m0_write;
    req[1]     = m1_read | m1_write;
    rw_both[0] = m0_read & m0_write;
    rw_both[1] = m1_read & m1_write;
    if (owner >= 0 && rw_both[owner]) err_seen = 1'b1;
    if (owner < 0) begin
      if (req[0] && req[1]) owner = 1 - last_served;
      else if (req[0])      owner = 0;
      else if (req[1])      owner = 1;
    end else begin
      other = 1 - owner;
      if (!req[owner]) begin
        last_served = owner;
        accepts     = 0;
        owner       = req[other] ? other : -1;
      end else if (!mem_waitrequest) begin
        if (req[other] && accepts + 1 >= MH) begin
          last_served = owner;
          accepts     = 0;
          owner       = other;
        end else if (accepts < HOLD_MAX) begin
          accepts++;
        end
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    logic [31:0] e_grant, e_ctl, e_addr, e_wd, e_wait;
    e_grant = (owner < 0) ? 0 : (1 << owner);
    e_ctl   = 0;
    e_addr  = 0;
    e_wd    = 0;
    e_wait  = 32'h3;
    if (owner == 0) begin
      e_ctl  = {28'd0, m0_read, m0_write, m0_byteenable};
      e_addr = {12'd0, m0_address};
      e_wd   = {16'd0, m0_writedata};
      e_wait = {30'd0, 1'b1, mem_waitrequest};
    end else if (owner == 1) begin
      e_ctl  = {28'd0, m1_read, m1_write, m1_byteenable};
      e_addr = {12'd0, m1_address};
      e_wd   = {16'd0, m1_writedata};
      e_wait = {30'd0, mem_waitrequest, 1'b1};
    end
    chk({ph, " grant"}, {30'd0, grant}, e_grant);
    chk({ph, " mem_ctl"}, {28'd0, mem_read, mem_write, mem_byteenable}, e_ctl);
    chk({ph, " mem_addr"}, {12'd0, mem_address}, e_addr);
    chk({ph, " mem_wdata"}, {16'd0, mem_writedata}, e_wd);
    chk({ph, " waitreq"}, {30'd0, m1_waitrequest, m0_waitrequest}, e_wait);
    chk({ph, " perr"}, {31'd0, protocol_err}, {31'd0, err_seen});
    chk({ph, " rdata"}, {m1_readdata, m0_readdata}, {mem_readdata, mem_readdata});
  endtask

  // Inputs must be settled when this is called; it checks, advances the
  // model with the same inputs the DUT sees at the edge, then moves past it.
  task automatic tick(input string ph);
    #1;
    check_outputs(ph);
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_masters();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic rand_master(input int pct, input bit allow_both,
                             output logic rd, output logic wr);
    rd = 0;
    wr = 0;
    if ($urandom_range(0, 99) < pct) begin
      if (allow_both && $urandom_range(0, 15) == 0) begin
        rd = 1; wr = 1;
      end else begin
        rd = $urandom_range(0, 1);
        wr = ~rd;
      end
    end
  endtask

  initial begin
    model_reset();
    // Reset held with a pending request: nothing granted, master stalled.
    m0_read = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rst grant", {30'd0, grant}, 0);
    chk("rst mem_read", {31'd0, mem_read}, 0);
    chk("rst m0_wait", {31'd0, m0_waitrequest}, 1);
    chk("rst perr", {31'd0, protocol_err}, 0);
    reset_n = 1'b1;
    tick("rel");
    chk("rel grant01", {30'd0, grant}, 1);
    m0_read = 0;
    tick("rel_drop");
    tick("rel_idle");

    // Single master: four back-to-back accepted reads at 0..3.
    apply_reset();
    mem_waitrequest = 0;
    m0_read = 1; m0_address = 0;
    tick("single_req");
    for (int i = 0; i < 4; i++) begin
      m0_address = AW'(i);
      #1;
      chk("single addr", {12'd0, mem_address}, i);
      chk("single accept", {30'd0, mem_read, m0_waitrequest}, 32'h2);
      chk("single m1_wait", {31'd0, m1_waitrequest}, 1);
      tick("single");
    end
    idle_masters();
    tick("single_end");

    // Contention: both read continuously, 8/8 alternation starting with m0.
    apply_reset();
    m0_read = 1; m1_read = 1;
    tick("cont_req");
    for (int i = 0; i < 48; i++) begin
      #1;
      chk("rr_pattern", {30'd0, grant}, ((i / MH) % 2 == 0) ? 1 : 2);
      tick("cont");
    end
    idle_masters();
    tick("cont_end");
    tick("cont_idle");

    // Wait stall then drop handover.
    apply_reset();
    m0_read = 1; m0_address = 20'h00100;
    tick("ws_req");
    m1_write = 1; m1_address = 20'h0ABCD; m1_writedata = 16'h5A5A;
    mem_waitrequest = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("wait_hold", {30'd0, grant}, 1);
      tick("ws");
    end
    mem_waitrequest = 0;
    tick("ws_acc1");
    tick("ws_acc2");
    m0_read = 0;
    tick("ws_drop");
    m0_read = 1;
    #1;
    chk("drop grant10", {30'd0, grant}, 2);
    chk("drop m1 addr", {12'd0, mem_address}, 32'h0ABCD);
    chk("drop m1 wdata", {16'd0, mem_writedata}, 32'h5A5A);
    chk("drop m0 stalled", {31'd0, m0_waitrequest}, 1);
    tick("ws_m1");
    m1_write = 0;
    tick("ws_m1_drop");
    #1;
    chk("m0 regrant", {30'd0, grant}, 1);
    idle_masters();
    tick("ws_end");

    // Protocol error: granted m1 asserts read and write together.
    apply_reset();
    m1_read = 1; m1_write = 1;
    tick("pe_req");
    tick("pe_both");
    m1_read = 0; m1_write = 0;
    #1;
    chk("perr set", {31'd0, protocol_err}, 1);
    for (int i = 0; i < 3; i++) tick("pe_idle");
    chk("perr sticky", {31'd0, protocol_err}, 1);

    // Reset asserted mid-transfer drops the bus asynchronously.
    m0_read = 1; mem_waitrequest = 1;
    tick("mr_req");
    tick("mr_wait");
    reset_n = 1'b0;
    #1;
    chk("midrst grant", {30'd0, grant}, 0);
    chk("midrst mem_read", {31'd0, mem_read}, 0);
    chk("midrst m0_wait", {31'd0, m0_waitrequest}, 1);
    chk("midrst perr", {31'd0, protocol_err}, 0);
    idle_masters();
    mem_waitrequest = 0;
    apply_reset();

    // Randomized traffic against the model.
    for (int ph = 0; ph < 4; ph++) begin
      int pct0, pct1;
      pct0 = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 95 : 70;
      pct1 = (ph == 0) ? 90 : (ph == 1) ? 30 : (ph == 2) ? 10 : 70;
      for (int c = 0; c < 600; c++) begin
        logic r, w;
        rand_master(pct0, ph == 3, r, w);
        m0_read = r; m0_write = w;
        rand_master(pct1, ph == 3, r, w);
        m1_read = r; m1_write = w;
        m0_address      = AW'($urandom);
        m1_address      = AW'($urandom);
        m0_byteenable   = BW'($urandom);
        m1_byteenable   = BW'($urandom);
        m0_writedata    = DW'($urandom);
        m1_writedata    = DW'($urandom);
        mem_readdata    = DW'($urandom);
        mem_waitrequest = ($urandom_range(0, 99) < 30);
        tick("rand");
      end
      idle_masters();
      tick("rand_gap");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
